// File: rtl/uart_debug_host.sv
// uart_debug_host
// Host-side initiator for the UART debug SRAM protocol. One read or write
// request is accepted at a time and serialised as command, address and
// optional data bytes into a uart_tx byte stream. For reads, the two-byte
// reply (high byte first) is collected from a uart_rx byte stream under a
// per-byte timeout.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   req_valid      request present
//   req_ready      block idle; request accepted when req_valid & req_ready
//   req_write      1 = write, 0 = read
//   req_addr       18-bit SRAM word address
//   req_wdata      16-bit write data (ignored for reads)
//   rsp_valid      one-cycle completion pulse
//   rsp_rdata      read data, valid with rsp_valid
//   rsp_timeout    read reply timed out, valid with rsp_valid
//   tx_data        byte to uart_tx
//   tx_valid       byte valid towards uart_tx
//   tx_ready       uart_tx can take the byte
//   rx_data        byte from uart_rx
//   rx_valid       one-cycle strobe per received byte, no backpressure
//   busy           high in every state except IDLE
module uart_debug_host #(
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [17:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        busy
);

    localparam logic [23:0] LIMIT = 24'(TIMEOUT);

    typedef enum logic [3:0] {
        IDLE, CMD, AH, AL, DH, DL, RH, RL, DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        wr;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [23:0] cnt;
    logic        accept;
    logic        tx_fire;
    logic        expire;

    assign accept  = req_valid && (state == IDLE);
    assign tx_fire = tx_valid && tx_ready;

    // The reply wait expires on the edge where the counter would reach
    // LIMIT, so DONE is entered exactly LIMIT cycles after the last
    // command byte or the last received reply byte.
    assign expire = (cnt >= (LIMIT - 24'd1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. In the reply states a received byte always wins
    // over a timeout that expires in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid) state_next = CMD;
            CMD:  if (tx_fire) state_next = AH;
            AH:   if (tx_fire) state_next = AL;
            AL:   if (tx_fire) state_next = wr ? DH : RH;
            DH:   if (tx_fire) state_next = DL;
            DL:   if (tx_fire) state_next = DONE;
            RH: begin
                if (rx_valid) begin
                    state_next = RL;
                end else if (expire) begin
                    state_next = DONE;
                end
            end
            RL: begin
                if (rx_valid || expire) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture, reply latching and the reply timeout counter.
    // The request fields are frozen at acceptance so the requester may
    // change its inputs while the frame is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr          <= 1'b0;
            addr        <= 18'h0;
            wdata       <= 16'h0;
            rsp_rdata   <= 16'h0;
            rsp_timeout <= 1'b0;
            cnt         <= 24'h0;
        end else begin
            if (accept) begin
                wr          <= req_write;
                addr        <= req_addr;
                wdata       <= req_wdata;
                rsp_timeout <= 1'b0;
            end
            if ((state == AL) && tx_fire) begin
                cnt <= 24'h0;
            end else if ((state == RH) || (state == RL)) begin
                if (rx_valid) begin
                    cnt <= 24'h0;
                    if (state == RH) begin
                        rsp_rdata[15:8] <= rx_data;
                    end else begin
                        rsp_rdata[7:0] <= rx_data;
                    end
                end else begin
                    if (cnt != LIMIT) begin
                        cnt <= cnt + 24'd1;
                    end
                    if (expire) begin
                        rsp_timeout <= 1'b1;
                    end
                end
            end
        end
    end

    // Outputs decoded from the registered state; tx_data only changes on
    // a state change, so it is stable while a byte waits for tx_ready.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        rsp_valid = (state == DONE);
        case (state)
            CMD: begin
                tx_valid = 1'b1;
                tx_data  = {wr, 5'b00000, addr[17:16]};
            end
            AH: begin
                tx_valid = 1'b1;
                tx_data  = addr[15:8];
            end
            AL: begin
                tx_valid = 1'b1;
                tx_data  = addr[7:0];
            end
            DH: begin
                tx_valid = 1'b1;
                tx_data  = wdata[15:8];
            end
            DL: begin
                tx_valid = 1'b1;
                tx_data  = wdata[7:0];
            end
            default: begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        endcase
    end

endmodule
